// File: rtl/ram_host_adapter.sv
// ram_host_adapter
// Host-side front end for one port of a dual-port synchronous RAM. It turns
// byte-addressed host requests into word-addressed RAM accesses. Reads wait
// one cycle for the RAM's registered data and return it as a registered
// response. Full-word writes go straight through. Partially masked writes
// read the old word first and then write back the merged word.
module ram_host_adapter #(
   parameter int dat_width = 32,
   parameter int adr_width = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   host_req_i,
   output logic                   host_ack_o,
   input  logic                   host_we_i,
   input  logic [adr_width-1:0]   host_addr_i,
   input  logic [dat_width/8-1:0] host_be_i,
   input  logic [dat_width-1:0]   host_wdata_i,
   output logic                   host_resp_o,
   output logic [dat_width-1:0]   host_rdata_o,
   output logic [adr_width-1:0]   ram_adr_o,
   output logic [dat_width-1:0]   ram_dat_o,
   output logic                   ram_we_o,
   input  logic [dat_width-1:0]   ram_dat_i
);

   localparam int BeW  = dat_width / 8;
   localparam int LsbW = $clog2(BeW);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RMW
   } state_t;

   state_t                 r_state;
   logic                   r_resp;
   logic [dat_width-1:0]   r_rdata;
   logic [adr_width-1:0]   r_addr;
   logic [BeW-1:0]         r_be;
   logic [dat_width-1:0]   r_wdata;

   logic [adr_width-1:0]   w_waddr;
   logic                   w_idle;
   logic                   w_accept;
   logic                   w_beFull;
   logic                   w_beNone;
   logic                   w_fullWrite;
   logic                   w_rmwWrite;
   logic [dat_width-1:0]   w_merged;

   // The shift drops the byte offset and zero-fills the top of the word address.
   assign w_waddr     = host_addr_i >> LsbW;
   assign w_idle      = (r_state == IDLE);
   assign w_accept    = !rst && w_idle && host_req_i;
   assign w_beFull    = &host_be_i;
   assign w_beNone    = (host_be_i == '0);
   assign w_fullWrite = w_accept && host_we_i && w_beFull;
   assign w_rmwWrite  = !rst && (r_state == RMW);

   assign host_ack_o   = w_accept;
   assign host_resp_o  = r_resp;
   assign host_rdata_o = r_rdata;
   assign ram_we_o     = w_fullWrite || w_rmwWrite;
   assign ram_adr_o    = (r_state == RMW) ? r_addr : w_waddr;
   assign ram_dat_o    = (r_state == RMW) ? w_merged : host_wdata_i;

   // Merge the latched write bytes over the old word that the RAM returns
   always_comb begin
      w_merged = ram_dat_i;
      for (int k = 0; k < BeW; k++) begin
         if (r_be[k]) begin
            w_merged[8*k +: 8] = r_wdata[8*k +: 8];
         end
      end
   end

   // Control FSM: register read responses and latch partial-write context
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_resp  <= 1'b0;
         r_rdata <= '0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
      end else begin
         r_resp <= 1'b0;
         case (r_state)
            IDLE: begin
               if (host_req_i) begin
                  if (!host_we_i) begin
                     r_state <= RD_WAIT;
                  end else if (!w_beFull && !w_beNone) begin
                     r_addr  <= w_waddr;
                     r_be    <= host_be_i;
                     r_wdata <= host_wdata_i;
                     r_state <= RMW;
                  end
               end
            end
            RD_WAIT: begin
               r_rdata <= ram_dat_i;
               r_resp  <= 1'b1;
               r_state <= IDLE;
            end
            RMW: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_host_adapter.sv
// Testbench for ram_host_adapter. A small RAM model with registered read data
// sits behind the adapter. Read expectations go into a scoreboard queue when
// the read is issued. A separate monitor pops and checks them whenever the
// adapter raises its response. Expected values are computed by hand.
module tb_ram_host_adapter;

   logic        clk = 1'b0;
   logic        rst;
   logic        hostReq;
   logic        hostAck;
   logic        hostWe;
   logic [31:0] hostAddr;
   logic [3:0]  hostBe;
   logic [31:0] hostWdata;
   logic        hostResp;
   logic [31:0] hostRdata;
   logic [31:0] ramAdr;
   logic [31:0] ramDatOut;
   logic        ramWe;
   logic [31:0] ramDatIn;

   logic [31:0] mem [0:63];
   int          cyc = 0;
   int          vectors = 0;
   int          errors = 0;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t sbq [$];

   ram_host_adapter #(.dat_width(32), .adr_width(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .host_req_i  (hostReq),
      .host_ack_o  (hostAck),
      .host_we_i   (hostWe),
      .host_addr_i (hostAddr),
      .host_be_i   (hostBe),
      .host_wdata_i(hostWdata),
      .host_resp_o (hostResp),
      .host_rdata_o(hostRdata),
      .ram_adr_o   (ramAdr),
      .ram_dat_o   (ramDatOut),
      .ram_we_o    (ramWe),
      .ram_dat_i   (ramDatIn)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to time-stamp expected responses
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAM model: read-first, data valid the cycle after the address
   always @(posedge clk) begin
      if (ramWe) mem[6'(ramAdr)] <= ramDatOut;
      ramDatIn <= mem[6'(ramAdr)];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we,
                                input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata);
      hostReq   = req;
      hostWe    = we;
      hostAddr  = addr;
      hostBe    = be;
      hostWdata = wdata;
   endtask

   task automatic issueRead(input logic [31:0] addr, input logic [31:0] expData);
      exp_t e;
      applyStimulus(1'b1, 1'b0, addr, 4'h0, 32'h0);
      e.data = expData;
      e.due  = cyc + 2;
      sbq.push_back(e);
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop the scoreboard on every response and flag late or stray ones
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
         vectors++;
         errors++;
         $display("[TB] FAIL resp_missing: got none, expected 0x%08h at cycle %0d",
                  sbq[0].data, sbq[0].due);
         void'(sbq.pop_front());
      end
      if (hostResp) begin
         if (sbq.size() == 0) begin
            vectors++;
            errors++;
            $display("[TB] FAIL resp_unexpected: got 0x%08h, expected no response (cycle %0d)",
                     hostRdata, cyc);
         end else begin
            e = sbq.pop_front();
            checkOutput("resp_data", hostRdata, e.data);
            checkOutput("resp_cycle", cyc, e.due);
         end
      end
   end

   logic [31:0] burstData [0:3];

   initial begin
      burstData[0] = 32'hC0DE0000;
      burstData[1] = 32'hC0DE1111;
      burstData[2] = 32'hC0DE2222;
      burstData[3] = 32'hC0DE3333;

      // Reset held for three cycles while a request is pending
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         settle();
         checkOutput("rst_ack", {31'b0, hostAck}, 32'h0);
         checkOutput("rst_we", {31'b0, ramWe}, 32'h0);
         tick();
      end
      settle();
      checkOutput("rst_resp", {31'b0, hostResp}, 32'h0);
      checkOutput("rst_rdata", hostRdata, 32'h0);
      tick();

      // Full write in the first cycle after reset
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      settle();
      checkOutput("full_ack", {31'b0, hostAck}, 32'h1);
      checkOutput("full_we", {31'b0, ramWe}, 32'h1);
      checkOutput("full_adr", ramAdr, 32'h4);
      checkOutput("full_dat", ramDatOut, 32'hDEADBEEF);
      tick();

      // Read it back on the very next cycle
      issueRead(32'h10, 32'hDEADBEEF);
      settle();
      checkOutput("rd_ack", {31'b0, hostAck}, 32'h1);
      checkOutput("rd_we", {31'b0, ramWe}, 32'h0);
      checkOutput("rd_adr", ramAdr, 32'h4);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      settle();
      checkOutput("rdwait_ack", {31'b0, hostAck}, 32'h0);
      tick();

      // Preload word 4, then a partial write with be=0x5
      applyStimulus(1'b1, 1'b1, 32'h10, 4'hF, 32'h11223344);
      settle();
      checkOutput("preload_we", {31'b0, ramWe}, 32'h1);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h10, 4'h5, 32'hAABBCCDD);
      settle();
      checkOutput("pw_ack", {31'b0, hostAck}, 32'h1);
      checkOutput("pw_we_T", {31'b0, ramWe}, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      settle();
      checkOutput("rmw_we", {31'b0, ramWe}, 32'h1);
      checkOutput("rmw_adr", ramAdr, 32'h4);
      checkOutput("rmw_dat", ramDatOut, 32'h11BB33DD);
      checkOutput("rmw_ack", {31'b0, hostAck}, 32'h0);
      tick();
      issueRead(32'h10, 32'h11BB33DD);
      settle();
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      settle();
      tick();

      // be=0 write does nothing; misaligned read still hits word 4
      applyStimulus(1'b1, 1'b1, 32'h10, 4'h0, 32'h12345678);
      settle();
      checkOutput("be0_ack", {31'b0, hostAck}, 32'h1);
      checkOutput("be0_we", {31'b0, ramWe}, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      settle();
      checkOutput("be0_we_next", {31'b0, ramWe}, 32'h0);
      tick();
      issueRead(32'h13, 32'h11BB33DD);
      settle();
      checkOutput("misalign_adr", ramAdr, 32'h4);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      settle();
      tick();

      // Four back-to-back full writes to words 8..11
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h20 + 32'(i * 4), 4'hF, burstData[i]);
         settle();
         checkOutput("burst_wr_ack", {31'b0, hostAck}, 32'h1);
         checkOutput("burst_wr_we", {31'b0, ramWe}, 32'h1);
         checkOutput("burst_wr_adr", ramAdr, 32'(8 + i));
         tick();
      end

      // Four reads, the next one held pending during each wait cycle
      for (int i = 0; i < 4; i++) begin
         issueRead(32'h20 + 32'(i * 4), burstData[i]);
         settle();
         checkOutput("burst_rd_ack", {31'b0, hostAck}, 32'h1);
         tick();
         if (i < 3) applyStimulus(1'b1, 1'b0, 32'h20 + 32'((i + 1) * 4), 4'h0, 32'h0);
         else       applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
         settle();
         checkOutput("burst_wait_ack", {31'b0, hostAck}, 32'h0);
         tick();
      end
      tick();
      tick();

      // Reset during the merge cycle of a be=0x1 write must suppress the write
      applyStimulus(1'b1, 1'b1, 32'h10, 4'hF, 32'h11223344);
      settle();
      tick();
      applyStimulus(1'b1, 1'b1, 32'h10, 4'h1, 32'h000000FF);
      settle();
      checkOutput("rstrmw_ack", {31'b0, hostAck}, 32'h1);
      tick();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      settle();
      checkOutput("rstrmw_we", {31'b0, ramWe}, 32'h0);
      checkOutput("rstrmw_ack0", {31'b0, hostAck}, 32'h0);
      tick();
      rst = 1'b0;
      issueRead(32'h10, 32'h11223344);
      settle();
      checkOutput("post_rst_ack", {31'b0, hostAck}, 32'h1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) tick();

      settle();
      checkOutput("queue_drained", 32'(sbq.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/ram_host_adapter.md
# ram_host_adapter

Front-end for one port of the dual-port synchronous RAM. It accepts byte-addressed host requests on a req/ack interface with byte enables. It converts them into word-addressed RAM port accesses. Byte-masked writes become read-modify-write sequences, and registered read responses absorb the RAM's one-cycle read latency. One instance sits directly upstream of each RAM port, for example instruction fetch on port 0 and data load/store on port 1.

## Interface

Parameters:
- dat_width, 32, data width in bits; multiple of 8, at least 16.
- adr_width, 32, width of host and RAM address buses.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- rst, in, 1, reset; synchronous, active-high.
- host_req_i, in, 1, request valid.
- host_ack_o, out, 1, request accepted this cycle (combinational).
- host_we_i, in, 1, 1 = write, 0 = read.
- host_addr_i, in, adr_width, byte address; low $clog2(dat_width/8) bits ignored.
- host_be_i, in, dat_width/8, byte enables for writes; bit k covers bits [8k+7:8k].
- host_wdata_i, in, dat_width, write data.
- host_resp_o, out, 1, read data valid; one-cycle pulse; registered.
- host_rdata_o, out, dat_width, read data; registered.
- ram_adr_o, out, adr_width, RAM word address.
- ram_dat_o, out, dat_width, RAM write data.
- ram_we_o, out, 1, RAM write enable.
- ram_dat_i, in, dat_width, RAM registered read data, valid the cycle after the address is presented.

## Operation

- Word address: waddr = host_addr_i >> $clog2(dat_width/8), zero-extended to adr_width.
- FSM states: IDLE, RD_WAIT, RMW.
- IDLE:
  - host_ack_o = host_req_i.
  - ram_adr_o = waddr.
  - ram_dat_o = host_wdata_i.
  - ram_we_o = 0 unless a full write is accepted.
- IDLE, accepted read: stay on waddr with ram_we_o=0, then go to RD_WAIT.
- IDLE, accepted write with host_be_i all ones: ram_we_o=1 in the same cycle, stay in IDLE, no response.
- IDLE, accepted write with host_be_i = 0: no RAM write, stay in IDLE, no response.
- IDLE, accepted write with any other host_be_i:
  - ram_we_o=0 (read of the old word).
  - Latch waddr, be and wdata.
  - Go to RMW.
- RD_WAIT:
  - host_ack_o=0.
  - Register host_rdata_o <= ram_dat_i and host_resp_o <= 1.
  - Go to IDLE.
- RMW:
  - host_ack_o=0.
  - ram_adr_o = latched address, ram_we_o=1.
  - ram_dat_o byte k = latched be[k] ? latched wdata byte k : ram_dat_i byte k.
  - Go to IDLE.
- host_resp_o is 0 in every cycle other than the one following RD_WAIT.
- host_rdata_o holds its last value between responses.
- Writes never produce a response.
- While rst=1: host_ack_o=0, ram_we_o=0 (combinationally forced).
- On reset: state <= IDLE, host_resp_o <= 0, host_rdata_o <= 0, latched regs <= 0.
- Reset asserted in RD_WAIT drops the response.
- Reset asserted in RMW suppresses the merged write; the RAM word is unchanged.

## Timing

- Read accepted at cycle T: host_resp_o=1 with data in T+2; next accept possible in T+2.
- Read throughput: one read per 2 cycles.
- Full-word write: accepted and written at cycle T; back-to-back every cycle.
- Partial write accepted at T: merged write issued in T+1; next accept possible in T+2.
- Read-after-write to the same address: because the write retires at the edge ending its cycle, a read accepted in the next IDLE cycle returns the new data.
- Host must hold request fields stable while host_req_i=1 and host_ack_o=0.
- Only the accept cycle's values are used, except that RMW uses the latched copies.

## Test plan

- Reset: hold rst 3 cycles with host_req_i=1 -> host_ack_o=0, ram_we_o=0, host_resp_o=0, host_rdata_o=0. After release, the first IDLE cycle shows ack=1.
- Full write then read (dat_width=32):
  - Write 0xDEADBEEF to byte address 0x10 with be=0xF -> ram_adr_o=4, ram_we_o=1 in the same cycle.
  - Read 0x10 on the next cycle -> host_resp_o pulses 2 cycles later with 0xDEADBEEF.
- Partial write:
  - Preload word 4 = 0x11223344.
  - Write 0xAABBCCDD with be=0x5 -> cycle T has ram_we_o=0 and ack=1; cycle T+1 has ram_we_o=1, ram_dat_o=0x11BB33DD, ack=0.
  - A read afterwards returns 0x11BB33DD.
- be=0 write and misaligned address:
  - Write be=0 -> no ram_we_o pulse.
  - Read byte address 0x13 -> ram_adr_o=4.
- Back-to-back traffic:
  - 4 consecutive full writes -> 4 consecutive ram_we_o cycles.
  - 4 reads -> responses spaced 2 cycles apart, in order, correct data.
- Reset mid-RMW:
  - Assert rst during the RMW cycle of a be=0x1 write to word 4 holding 0x11223344 -> no write.
  - After reset, a read returns 0x11223344.
